register_write_arbiter: RTL

- Shares the single write port of the register file between two requesters (port 0: execute writeback, port 1: load writeback).
- Arbitration is round-robin with valid/ready handshakes; the winning write is registered.
- Output is a one-cycle, one-hot per-register set strobe plus latched write data, driving each register instance's data/set inputs.
- Register 0 is hardwired zero: writes to it are accepted and discarded.

---
 rtl/register_file_pkg.sv | 16 +
 rtl/register_write_arbiter_address_decoder.sv | 26 ++
 rtl/register_write_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared constants for the register file: default geometry, the hardwired-zero
// register index and the write-port indices used by the write arbiter.
package register_file_pkg;

    localparam int BIT_WIDTH  = 32;
    localparam int REG_COUNT  = 32;
    localparam int ADDR_WIDTH = 5;

    // Register 0 always reads as zero, so writes to it are dropped.
    localparam int REG_ZERO = 0;

    // Write-port indices as seen on last_grant.
    localparam logic PORT_EXEC = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

endpackage

// File: rtl/register_write_arbiter_address_decoder.sv
// Register index to one-hot select. Register 0 and indices at or beyond
// REG_COUNT produce no select bit, so a write to them falls on the floor.
// Also intended for the read-port select logic.
module address_decoder
    import register_file_pkg::*;
#(
    parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH,
    parameter int REG_COUNT  = register_file_pkg::REG_COUNT
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  enable,
    output logic [REG_COUNT-1:0]  onehot,
    output logic                  hit
);

    // One select bit per real register; zero register never selected.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            onehot[i] = enable && (int'(addr) == i) && (i != REG_ZERO);
        end
    end

    assign hit = |onehot;

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// execute writeback (port 0) and the load writeback (port 1).
//
// Handshake: a transfer happens on any cycle where valid and ready are both
// high. The requester keeps valid/addr/data stable until it sees ready.
// ready is combinational from valid, hold, reset and last_grant only; valid
// must never depend on ready in the same cycle.
//
// The accepted write is registered: write_set pulses for one cycle the cycle
// after acceptance, and write_data holds the last real write when idle.
module register_write_arbiter
    import register_file_pkg::*;
#(
    parameter int BIT_WIDTH  = register_file_pkg::BIT_WIDTH,
    parameter int REG_COUNT  = register_file_pkg::REG_COUNT,
    parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [BIT_WIDTH-1:0]  req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [BIT_WIDTH-1:0]  req1_data,
    output logic                  req1_ready,
    output logic [REG_COUNT-1:0]  write_set,
    output logic [BIT_WIDTH-1:0]  write_data,
    output logic                  last_grant
);

    logic                  grant0;
    logic                  grant1;
    logic                  grant_any;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BIT_WIDTH-1:0]  sel_data;
    logic [REG_COUNT-1:0]  decoded;
    logic                  hit;

    // Round-robin choice: under contention the port that did not win last
    // time goes first; reset and hold block every grant.
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        sel_addr = req0_addr;
        sel_data = req0_data;
        if (!reset && !hold) begin
            grant0 = req0_valid && (!req1_valid || (last_grant == PORT_LOAD));
            grant1 = req1_valid && (!req0_valid || (last_grant == PORT_EXEC));
        end
        if (grant1) begin
            sel_addr = req1_addr;
            sel_data = req1_data;
        end
    end

    assign grant_any  = grant0 || grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    address_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_decoder (
        .addr   (sel_addr),
        .enable (grant_any),
        .onehot (decoded),
        .hit    (hit)
    );

    // Register the winning write; dropped addresses leave write_data alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_set  <= '0;
            write_data <= '0;
            last_grant <= PORT_LOAD;
        end else begin
            write_set <= decoded;
            if (hit) begin
                write_data <= sel_data;
            end
            if (grant_any) begin
                last_grant <= grant1 ? PORT_LOAD : PORT_EXEC;
            end
        end
    end

endmodule
